// File: rtl/fifo_rd_prefetch_if.sv
// Read-side bundle between the aFifo read port, the prefetcher and the consumer.
// The pf_level signal exists only when PREFETCH_LEVEL_EN is defined.
interface fifo_rd_prefetch_if #(
  parameter int DATASIZE   = 8,
  parameter int RD_LATENCY = 1
);
  logic                mem_empty;
  logic                mem_rinc;
  logic [DATASIZE-1:0] mem_rdata;
  logic [DATASIZE-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;
`ifdef PREFETCH_LEVEL_EN
  localparam int BUFDEPTH = RD_LATENCY + 1;
  localparam int CW       = $clog2(BUFDEPTH + 1);
  logic [CW-1:0]       pf_level;
`endif

  // master: the prefetcher, which issues rinc and sources dout
  modport master (
    input  mem_empty, mem_rdata, dout_ready,
    output mem_rinc, dout, dout_valid
`ifdef PREFETCH_LEVEL_EN
    , output pf_level
`endif
  );

  modport slave (
    output mem_empty, mem_rdata, dout_ready,
    input  mem_rinc, dout, dout_valid
`ifdef PREFETCH_LEVEL_EN
    , input pf_level
`endif
  );
endinterface

// File: rtl/fifo_rd_prefetch.sv
// Prefetching read front-end for a registered-read aFifo: keeps RD_LATENCY+1 skid entries
// so dout streams one word per clock. PREFETCH_LEVEL_EN adds the pf_level occupancy output.
module fifo_rd_prefetch #(
  parameter int DATASIZE   = 8,
  parameter int RD_LATENCY = 1
) (
  input logic                rclk,
  input logic                rrst,
  fifo_rd_prefetch_if.master bus
);
  localparam int BUFDEPTH = RD_LATENCY + 1;
  localparam int CW       = $clog2(BUFDEPTH + 1);
  localparam int PW       = $clog2(BUFDEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(BUFDEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(BUFDEPTH);
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(BUFDEPTH);

  logic [RD_LATENCY-1:0] pipe;
  logic [DATASIZE-1:0]   skid [BUFDEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         occ;
  logic [CW-1:0]         inflight;
  logic [CW:0]           demand;
  logic                  push;
  logic                  pop;
  logic                  valid;
  logic                  rinc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(pipe[i]);
  end

  assign push   = pipe[RD_LATENCY-1];
  assign valid  = (occ != '0);
  assign pop    = valid && bus.dout_ready;
  assign demand = {1'b0, occ} + {1'b0, inflight} - {{CW{1'b0}}, pop};
  // occ reads zero during reset, so rinc must be gated explicitly
  assign rinc   = !rrst && !bus.mem_empty && (demand < DEPTH_W);

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= rinc;
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < BUFDEPTH; i++) skid[i] <= '0;
    end else begin
      if (push) begin
        skid[wr_ptr] <= bus.mem_rdata;
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      occ <= occ + CW'(1);
      else if (pop && !push) occ <= occ - CW'(1);
    end
  end

  assign bus.mem_rinc   = rinc;
  assign bus.dout       = skid[rd_ptr];
  assign bus.dout_valid = valid;
`ifdef PREFETCH_LEVEL_EN
  assign bus.pf_level   = occ;
`endif

  // rinc throttling keeps occ+inflight <= BUFDEPTH, so a push into a full buffer is a design error
  a_no_overflow: assert property (@(posedge rclk) disable iff (rrst)
    !(push && !pop && (occ == DEPTH_C)));
endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Bench for fifo_rd_prefetch: two instances (RD_LATENCY 1 and 3) share one write stream,
// each behind its own registered-read aFifo model and in-order scoreboard.
module tb_fifo_rd_prefetch;
  logic       rclk = 1'b0;
  logic       rrst;
  logic       ready;
  logic       wr_en;
  logic [7:0] wr_data;

  always #5 rclk = ~rclk;

  logic [7:0] wlog [512];
  int         wcnt = 0;
  int         nvec = 0;
  int         nerr = 0;

  logic [1:0] rinc_w;
  logic [1:0] valid_w;
  logic [1:0] empty_w;
  logic [7:0] dout_w [2];
  int         rcnt  [2] = '{0, 0};
  int         pops  [2] = '{0, 0};
  int         rincs [2] = '{0, 0};
`ifdef PREFETCH_LEVEL_EN
  int         level_w [2];
`endif

  always @(posedge rclk) begin
    if (wr_en) begin
      wlog[wcnt] <= wr_data;
      wcnt       <= wcnt + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int RDL = (g == 0) ? 1 : 3;

    fifo_rd_prefetch_if #(.DATASIZE(8), .RD_LATENCY(RDL)) bus ();
    fifo_rd_prefetch #(.DATASIZE(8), .RD_LATENCY(RDL)) dut (
      .rclk (rclk),
      .rrst (rrst),
      .bus  (bus)
    );

    logic [7:0] stg [RDL];
    logic       empty;
    int         rptr;

    assign bus.mem_empty  = empty;
    assign bus.mem_rdata  = stg[RDL-1];
    assign bus.dout_ready = ready;
    assign rinc_w[g]      = bus.mem_rinc;
    assign valid_w[g]     = bus.dout_valid;
    assign empty_w[g]     = empty;
    assign dout_w[g]      = bus.dout;
`ifdef PREFETCH_LEVEL_EN
    assign level_w[g]     = int'(bus.pf_level);
`endif

    // aFifo model: read pointer and rempty share rrst; registered read of RDL stages
    always @(posedge rclk or posedge rrst) begin
      if (rrst) begin
        rptr  <= wcnt;
        empty <= 1'b1;
        for (int i = 0; i < RDL; i++) stg[i] <= 8'h00;
      end else begin
        rptr   <= rptr + int'(bus.mem_rinc);
        empty  <= ((rptr + int'(bus.mem_rinc)) == (wcnt + int'(wr_en)));
        stg[0] <= bus.mem_rinc ? wlog[rptr] : 8'hEE;
        for (int i = 1; i < RDL; i++) stg[i] <= stg[i-1];
      end
    end

    always @(negedge rclk) begin
      if (rrst) begin
        rcnt[g] = wcnt;
      end else begin
        if (bus.mem_rinc) begin
          rincs[g]++;
          check($sformatf("rinc_while_empty_rdl%0d", RDL), int'(empty), 0);
        end
        if (bus.dout_valid && ready) begin
          check($sformatf("pop_data_rdl%0d_idx%0d", RDL, rcnt[g]), int'(bus.dout), int'(wlog[rcnt[g]]));
          rcnt[g]++;
          pops[g]++;
        end
      end
    end
  end

  typedef struct packed {
    logic       wr;
    logic [7:0] wd;
    logic       rdy;
    logic [1:0] rinc;
    logic [1:0] val;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl [8];
  int   p0 [2];
  int   r0 [2];
  int   first [2];
  int   last [2];

  initial begin
    // single word, ready low: bit0 = RD_LATENCY 1 instance, bit1 = RD_LATENCY 3 instance
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 2'b00, 2'b00, 8'hA5};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 2'b11, 2'b00, 8'hA5};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 8'hA5};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 2'b00, 2'b01, 8'hA5};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 2'b00, 2'b01, 8'hA5};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 2'b00, 2'b11, 8'hA5};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 2'b00, 2'b11, 8'hA5};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 8'hA5};

    rrst    = 1'b1;
    ready   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (2) step();
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reset_rinc_g%0d", g), int'(rinc_w[g]), 0);
      check($sformatf("reset_valid_g%0d", g), int'(valid_w[g]), 0);
      check($sformatf("reset_dout_g%0d", g), int'(dout_w[g]), 0);
    end
    step();
    rrst = 1'b0;

    // T2 single word, cycle-exact table
    for (int i = 0; i < 8; i++) begin
      step();
      wr_en   = tbl[i].wr;
      wr_data = tbl[i].wd;
      ready   = tbl[i].rdy;
      @(negedge rclk);
      for (int g = 0; g < 2; g++) begin
        check($sformatf("t2_row%0d_rinc_g%0d", i, g), int'(rinc_w[g]), int'(tbl[i].rinc[g]));
        check($sformatf("t2_row%0d_valid_g%0d", i, g), int'(valid_w[g]), int'(tbl[i].val[g]));
        if (tbl[i].val[g]) check($sformatf("t2_row%0d_dout_g%0d", i, g), int'(dout_w[g]), int'(tbl[i].dout));
      end
    end

    // T3 streaming 64 words, ready high
    for (int g = 0; g < 2; g++) begin
      p0[g] = pops[g]; r0[g] = rincs[g]; first[g] = -1; last[g] = -1;
    end
    for (int k = 0; k < 100; k++) begin
      step();
      ready   = 1'b1;
      wr_en   = (k < 64);
      wr_data = 8'(k);
      @(negedge rclk);
      for (int g = 0; g < 2; g++) begin
        if (valid_w[g]) begin
          if (first[g] < 0) first[g] = k;
          last[g] = k;
        end
      end
    end
    check("t3_first_valid_rdl1", first[0], 3);
    check("t3_first_valid_rdl3", first[1], 5);
    check("t3_last_valid_rdl1", last[0], 66);
    check("t3_last_valid_rdl3", last[1], 68);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("t3_pops_g%0d", g), pops[g] - p0[g], 64);
      check($sformatf("t3_rincs_g%0d", g), rincs[g] - r0[g], 64);
    end

    // T4 backpressure: 16 words with ready low, then ready toggling 1010..
    for (int g = 0; g < 2; g++) begin
      p0[g] = pops[g]; r0[g] = rincs[g];
    end
    for (int k = 0; k < 30; k++) begin
      step();
      ready   = 1'b0;
      wr_en   = (k < 16);
      wr_data = 8'h40 + 8'(k);
      @(negedge rclk);
    end
    check("t4_rincs_stalled_rdl1", rincs[0] - r0[0], 2);
    check("t4_rincs_stalled_rdl3", rincs[1] - r0[1], 4);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("t4_valid_held_g%0d", g), int'(valid_w[g]), 1);
      check($sformatf("t4_dout_held_g%0d", g), int'(dout_w[g]), 8'h40);
    end
`ifdef PREFETCH_LEVEL_EN
    check("t6_level_full_rdl1", level_w[0], 2);
    check("t6_level_full_rdl3", level_w[1], 4);
`endif
    for (int k = 0; k < 80; k++) begin
      step();
      ready = (k % 2 == 0);
      @(negedge rclk);
    end
    for (int g = 0; g < 2; g++) begin
      check($sformatf("t4_pops_g%0d", g), pops[g] - p0[g], 16);
      check($sformatf("t4_rincs_g%0d", g), rincs[g] - r0[g], 16);
`ifdef PREFETCH_LEVEL_EN
      check($sformatf("t6_level_drained_g%0d", g), level_w[g], 0);
`endif
    end

    // T5 drain race: rempty rises with RD_LATENCY words still in flight
    for (int g = 0; g < 2; g++) begin
      p0[g] = pops[g]; r0[g] = rincs[g];
    end
    for (int k = 0; k < 20; k++) begin
      step();
      ready   = 1'b1;
      wr_en   = (k < 3);
      wr_data = 8'h80 + 8'(k);
      @(negedge rclk);
      if (k == 4) begin
        for (int g = 0; g < 2; g++) begin
          check($sformatf("t5_empty_c4_g%0d", g), int'(empty_w[g]), 1);
          check($sformatf("t5_rinc_c4_g%0d", g), int'(rinc_w[g]), 0);
        end
        check("t5_inflight_not_landed_rdl3", int'(valid_w[1]), 0);
      end
    end
    for (int g = 0; g < 2; g++) begin
      check($sformatf("t5_pops_g%0d", g), pops[g] - p0[g], 3);
      check($sformatf("t5_rincs_g%0d", g), rincs[g] - r0[g], 3);
    end

    // T1 reset mid-stream, then fresh words only
    for (int k = 0; k < 6; k++) begin
      step();
      ready   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 8'h10 + 8'(k);
    end
    #2;
    rrst  = 1'b1;
    wr_en = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("t1_rinc_in_reset_g%0d", g), int'(rinc_w[g]), 0);
      check($sformatf("t1_valid_in_reset_g%0d", g), int'(valid_w[g]), 0);
      check($sformatf("t1_dout_in_reset_g%0d", g), int'(dout_w[g]), 0);
    end
    repeat (2) step();
    rrst = 1'b0;
    for (int g = 0; g < 2; g++) p0[g] = pops[g];
    for (int k = 0; k < 30; k++) begin
      step();
      wr_en   = (k < 4);
      wr_data = 8'hC0 + 8'(k);
      @(negedge rclk);
    end
    for (int g = 0; g < 2; g++)
      check($sformatf("t1_pops_after_reset_g%0d", g), pops[g] - p0[g], 4);

`ifdef PREFETCH_LEVEL_EN
    // T6 level steps down one per pop with the aFifo empty
    for (int k = 0; k < 15; k++) begin
      step();
      ready   = 1'b0;
      wr_en   = (k < 2);
      wr_data = 8'hE0 + 8'(k);
      @(negedge rclk);
    end
    for (int g = 0; g < 2; g++) check($sformatf("t6_level2_g%0d", g), level_w[g], 2);
    for (int n = 1; n >= 0; n--) begin
      step();
      ready = 1'b1;
      step();
      ready = 1'b0;
      @(negedge rclk);
      for (int g = 0; g < 2; g++) check($sformatf("t6_level%0d_g%0d", n, g), level_w[g], n);
    end
`endif

    repeat (5) step();
    for (int g = 0; g < 2; g++)
      check($sformatf("all_delivered_g%0d", g), rcnt[g], wcnt);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
